// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Expected parity bit from the XOR-reduction of the data word.
  function automatic logic parity_bit(input logic xor_red, input logic even_par);
    return even_par ? xor_red : ~xor_red;
  endfunction

endpackage

// File: rtl/itf_rx_if.sv
// Serial line in, received word and status pulses out.
interface itf_rx_if #(
  parameter int unsigned PACK_SIZE = 8
);

  logic                 rx_bit;
  logic [PACK_SIZE-1:0] rx_byte_data;
  logic                 rx_byte_valid;
  logic                 rx_active;
  logic                 par_error;
  logic                 stop_error;

  // Receiver side: consumes the line, produces the word bus.
  modport master (
    input  rx_bit,
    output rx_byte_data,
    output rx_byte_valid,
    output rx_active,
    output par_error,
    output stop_error
  );

  // Line driver / word consumer side.
  modport slave (
    output rx_bit,
    input  rx_byte_data,
    input  rx_byte_valid,
    input  rx_active,
    input  par_error,
    input  stop_error
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/itf_rx.sv
// UART receiver: start-bit centring, LSB-first data, optional parity, stop check.
module itf_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned PACK_SIZE   = 8,
  parameter bit          PARITY_EN   = 1'b0,
  parameter bit          EVEN_PAR    = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  itf_rx_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned IDX_W = $clog2(PACK_SIZE);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_SIZE - 1);

  logic rx_s;

  rx_state_e            state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [PACK_SIZE-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 active_q, active_d;
  logic                 perr_q,   perr_d;
  logic                 serr_q,   serr_d;
  logic                 flag_q,   flag_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx_bit),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    active_d = active_q;
    perr_d   = perr_q;
    serr_d   = serr_q;
    flag_d   = flag_q;

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        valid_d  = 1'b0;
        serr_d   = 1'b0;
        perr_d   = 1'b0;
        flag_d   = 1'b0;
        active_d = 1'b0;
        if (!rx_s) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end

      // Re-check the line half a bit in to reject glitches.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          data_d[idx_q] = rx_s;
          idx_d         = idx_q + IDX_W'(1);
          cnt_d         = '0;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rx_s != parity_bit(^data_q, EVEN_PAR)) begin
            perr_d = 1'b1;
            flag_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Parity error pulse ends on entry; valid/stop status is issued on exit.
      STOP: begin
        perr_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          valid_d  = rx_s & ~flag_q;
          serr_d   = ~rx_s;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_byte_data  = data_q;
  assign bus.rx_byte_valid = valid_q;
  assign bus.rx_active     = active_q;
  assign bus.par_error     = perr_q;
  assign bus.stop_error    = serr_q;

endmodule

// File: tb/tb_itf_rx.sv
// Scoreboard bench for itf_rx: odd-parity instance plus a no-parity instance.
module tb_itf_rx;

  localparam int CPB = 5;

  typedef enum logic [1:0] {K_VALID, K_PAR, K_STOP, K_NONE} kind_e;
  typedef struct packed {
    kind_e      kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  itf_rx_if #(.PACK_SIZE(8)) bus_a ();
  itf_rx_if #(.PACK_SIZE(8)) bus_b ();

  itf_rx #(
    .CLK_PER_BIT (CPB),
    .PACK_SIZE   (8),
    .PARITY_EN   (1'b1),
    .EVEN_PAR    (1'b0)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  itf_rx #(
    .CLK_PER_BIT (CPB),
    .PACK_SIZE   (8),
    .PARITY_EN   (1'b0),
    .EVEN_PAR    (1'b1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t ev_a;
  ev_t ev_b;
  int  checks   = 0;
  int  failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t pop_a();
    if (q_a.size() == 0) return '{K_NONE, 8'h00};
    return q_a.pop_front();
  endfunction

  function automatic ev_t pop_b();
    if (q_b.size() == 0) return '{K_NONE, 8'h00};
    return q_b.pop_front();
  endfunction

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Every status pulse consumes one scoreboard entry of the matching kind.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_a.rx_byte_valid) begin
        ev_a = pop_a();
        check_eq("a_valid_kind", 32'(ev_a.kind), 32'(K_VALID));
        if (ev_a.kind == K_VALID) check_eq("a_data", 32'(bus_a.rx_byte_data), 32'(ev_a.data));
      end
      if (bus_a.par_error) begin
        ev_a = pop_a();
        check_eq("a_par_kind", 32'(ev_a.kind), 32'(K_PAR));
      end
      if (bus_a.stop_error) begin
        ev_a = pop_a();
        check_eq("a_stop_kind", 32'(ev_a.kind), 32'(K_STOP));
      end
      if (bus_b.rx_byte_valid) begin
        ev_b = pop_b();
        check_eq("b_valid_kind", 32'(ev_b.kind), 32'(K_VALID));
        if (ev_b.kind == K_VALID) check_eq("b_data", 32'(bus_b.rx_byte_data), 32'(ev_b.data));
      end
      if (bus_b.par_error || bus_b.stop_error) begin
        ev_b = pop_b();
        check_eq("b_err_kind", 32'(ev_b.kind), 32'(K_NONE) + 32'd1);
      end
    end
  end

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) bus_b.rx_bit = v;
    else     bus_a.rx_bit = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, par);
    drive_bit(sel, stop);
    if (sel) bus_b.rx_bit = 1'b1;
    else     bus_a.rx_bit = 1'b1;
  endtask

  task automatic idle_check(input string tag, input int n);
    repeat (n) @(posedge clk);
    #1;
    check_eq({tag, "_pending_a"}, 32'(q_a.size()), 32'd0);
    check_eq({tag, "_pending_b"}, 32'(q_b.size()), 32'd0);
    check_eq({tag, "_active_a"},  32'(bus_a.rx_active), 32'd0);
  endtask

  initial begin
    logic seen;
    bus_a.rx_bit = 1'b1;
    bus_b.rx_bit = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data",   32'(bus_a.rx_byte_data),  32'd0);
    check_eq("rst_valid",  32'(bus_a.rx_byte_valid), 32'd0);
    check_eq("rst_active", 32'(bus_a.rx_active),     32'd0);
    check_eq("rst_perr",   32'(bus_a.par_error),     32'd0);
    check_eq("rst_serr",   32'(bus_a.stop_error),    32'd0);
    check_eq("rst_b_act",  32'(bus_b.rx_active),     32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    q_a.push_back('{K_VALID, 8'hFE});
    send_frame(1'b0, 8'hFE, 1'b1, odd_par(8'hFE), 1'b1);
    idle_check("normal", 4 * CPB);
    check_eq("hold_data", 32'(bus_a.rx_byte_data), 32'hFE);

    q_a.push_back('{K_PAR, 8'h00});
    send_frame(1'b0, 8'hFE, 1'b1, ~odd_par(8'hFE), 1'b1);
    idle_check("bad_par", 4 * CPB);

    q_a.push_back('{K_STOP, 8'h00});
    send_frame(1'b0, 8'hFE, 1'b1, odd_par(8'hFE), 1'b0);
    idle_check("bad_stop", 6 * CPB);

    bus_a.rx_bit = 1'b0;
    @(posedge clk);
    #1;
    bus_a.rx_bit = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.rx_active) seen = 1'b1;
    end
    check_eq("glitch_active_seen", 32'(seen), 32'd1);
    idle_check("glitch", 2 * CPB);

    // Abort a frame part-way through the data bits.
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    check_eq("mid_active", 32'(bus_a.rx_active), 32'd1);
    bus_a.rx_bit = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_data",   32'(bus_a.rx_byte_data),  32'd0);
    check_eq("mid_rst_active", 32'(bus_a.rx_active),     32'd0);
    check_eq("mid_rst_valid",  32'(bus_a.rx_byte_valid), 32'd0);
    check_eq("mid_rst_perr",   32'(bus_a.par_error),     32'd0);
    check_eq("mid_rst_serr",   32'(bus_a.stop_error),    32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q_a.push_back('{K_VALID, 8'h5A});
    send_frame(1'b0, 8'h5A, 1'b1, 1'b1, 1'b1);
    idle_check("after_rst", 4 * CPB);

    q_b.push_back('{K_VALID, 8'h00});
    q_b.push_back('{K_VALID, 8'hFF});
    send_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    idle_check("b2b", 4 * CPB);
    check_eq("b2b_active_b", 32'(bus_b.rx_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
